// File: rtl/operand_editor.sv
// rtl/operand_editor.sv - push-button editor for FIELDS operand/function registers
// Optional auto-repeat of held inc/dec: define OPERAND_EDITOR_AUTOREPEAT_EN.
module operand_editor #(
  parameter int WIDTH         = 5,
  parameter int FIELDS        = 3,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int SEL_W         = (FIELDS <= 2) ? 1 : $clog2(FIELDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec,
  input  logic                    inc,
  input  logic                    prev,
  input  logic                    next,
  input  logic                    sat,
  output logic [FIELDS*WIDTH-1:0] fields,
  output logic [SEL_W-1:0]        sel,
  output logic                    val_chg,
  output logic                    sel_chg
);
  localparam int NB    = 4;
  localparam int B_DEC = 0;
  localparam int B_INC = 1;
  localparam int B_PRV = 2;
  localparam int B_NXT = 3;
  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]    lvl_q, lvl_d, lvl_dly_q, lvl_dly_d;
  logic [NB-1:0]    armed_q, armed_d, press;
  logic [1:0]       init_q, init_d;
  logic [CNT_W-1:0] db_cnt_q [NB];
  logic [CNT_W-1:0] db_cnt_d [NB];
  logic [WIDTH-1:0] fld_q [FIELDS];
  logic [WIDTH-1:0] fld_d [FIELDS];
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             val_chg_q, val_chg_d, sel_chg_q, sel_chg_d;
  logic             inc_ev, dec_ev, step_up, step_dn;

  assign raw = {next, prev, inc, dec};

  // A button is armed only once it has been seen released after reset, so a
  // press held through reset never produces an event.
  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    lvl_dly_d = lvl_q;
    init_d    = {init_q[0], 1'b1};
    armed_d   = armed_q | ({NB{init_q[1]}} & ~sync2_q);
    lvl_d     = lvl_q;
    for (int b = 0; b < NB; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != lvl_q[b]) begin
        if (db_cnt_q[b] == CNT_W'(DB_CYCLES - 1)) begin
          lvl_d[b] = ~lvl_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
    press = lvl_q & ~lvl_dly_q & armed_q;
  end

`ifdef OPERAND_EDITOR_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_fire;
  logic [NB-1:0]    held;

  assign held = lvl_q & armed_q;

  // Counts cycles since the press; after firing it reloads so the next fire
  // lands REPEAT_PERIOD cycles later.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_fire  = 1'b0;
    if (held[B_INC] ^ held[B_DEC]) begin
      if (press[B_INC] | press[B_DEC]) begin
        rpt_cnt_d = RPT_W'(1);
      end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY)) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_cnt_q <= '0;
    else     rpt_cnt_q <= rpt_cnt_d;
  end

  assign inc_ev = press[B_INC] | (rpt_fire & held[B_INC]);
  assign dec_ev = press[B_DEC] | (rpt_fire & held[B_DEC]);
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign inc_ev     = press[B_INC];
  assign dec_ev     = press[B_DEC];
`endif

  always_comb begin
    step_up   = inc_ev & ~dec_ev;
    step_dn   = dec_ev & ~inc_ev;
    val_chg_d = 1'b0;
    for (int i = 0; i < FIELDS; i++) begin
      fld_d[i] = fld_q[i];
      if (SEL_W'(i) == sel_q) begin
        if (step_up && !(sat && (fld_q[i] == '1))) begin
          fld_d[i]  = fld_q[i] + 1'b1;
          val_chg_d = 1'b1;
        end else if (step_dn && !(sat && (fld_q[i] == '0))) begin
          fld_d[i]  = fld_q[i] - 1'b1;
          val_chg_d = 1'b1;
        end
      end
    end
    sel_d = sel_q;
    if (press[B_NXT] && !press[B_PRV]) begin
      sel_d = (sel_q == SEL_W'(FIELDS - 1)) ? '0 : sel_q + 1'b1;
    end else if (press[B_PRV] && !press[B_NXT]) begin
      sel_d = (sel_q == '0) ? SEL_W'(FIELDS - 1) : sel_q - 1'b1;
    end
    sel_chg_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      armed_q   <= '0;
      init_q    <= '0;
      sel_q     <= '0;
      val_chg_q <= 1'b0;
      sel_chg_q <= 1'b0;
      for (int b = 0; b < NB; b++) db_cnt_q[b] <= '0;
      for (int i = 0; i < FIELDS; i++) fld_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      armed_q   <= armed_d;
      init_q    <= init_d;
      sel_q     <= sel_d;
      val_chg_q <= val_chg_d;
      sel_chg_q <= sel_chg_d;
      for (int b = 0; b < NB; b++) db_cnt_q[b] <= db_cnt_d[b];
      for (int i = 0; i < FIELDS; i++) fld_q[i] <= fld_d[i];
    end
  end

  for (genvar g = 0; g < FIELDS; g++) begin : g_pack
    assign fields[g*WIDTH +: WIDTH] = fld_q[g];
  end

  assign sel     = sel_q;
  assign val_chg = val_chg_q;
  assign sel_chg = sel_chg_q;
endmodule

// File: tb/tb_operand_editor.sv
// tb/tb_operand_editor.sv - randomized self-checking bench for operand_editor
module tb_operand_editor;
  localparam int W    = 5;
  localparam int F    = 3;
  localparam int DB   = 16;
  localparam int MAXV = (1 << W) - 1;
`ifdef OPERAND_EDITOR_AUTOREPEAT_EN
  localparam int HOLD_STEPS = 7;
`else
  localparam int HOLD_STEPS = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           dec = 1'b0, inc = 1'b0, prev = 1'b0, next = 1'b0, sat = 1'b0;
  logic [F*W-1:0] fields;
  logic [1:0]     sel;
  logic           val_chg, sel_chg;

  int total = 0;
  int bad   = 0;
  int m_f[F];
  int m_sel;

  always #5 clk = ~clk;

  operand_editor #(
    .WIDTH(W), .FIELDS(F), .DB_CYCLES(DB), .REPEAT_DELAY(50), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .rst(rst), .dec(dec), .inc(inc), .prev(prev), .next(next), .sat(sat),
    .fields(fields), .sel(sel), .val_chg(val_chg), .sel_chg(sel_chg)
  );

  // mask bits: 0 dec, 1 inc, 2 prev, 3 next
  task automatic model_apply(input logic [3:0] m, input logic s, output bit vch, output bit sch);
    int v;
    v = m_f[m_sel];
    if (m[1] && !m[0]) v = (s && v == MAXV) ? v : (v + 1) % (MAXV + 1);
    if (m[0] && !m[1]) v = (s && v == 0) ? v : (v + MAXV) % (MAXV + 1);
    vch = (v != m_f[m_sel]);
    m_f[m_sel] = v;
    sch = 1'b0;
    if (m[3] && !m[2]) begin m_sel = (m_sel + 1) % F; sch = 1'b1; end
    else if (m[2] && !m[3]) begin m_sel = (m_sel + F - 1) % F; sch = 1'b1; end
  endtask

  function automatic logic [F*W-1:0] model_fields();
    logic [F*W-1:0] e;
    for (int i = 0; i < F; i++) e[i*W +: W] = W'(m_f[i]);
    return e;
  endfunction

  task automatic press(input logic [3:0] m, input logic s, input int hold,
                       output int vc, output int sc, output int vf, output int sf);
    @(negedge clk);
    sat = s;
    {next, prev, inc, dec} = m;
    vc = 0; sc = 0; vf = -1; sf = -1;
    for (int c = 1; c <= hold + DB + 6; c++) begin
      @(negedge clk);
      if (val_chg) begin vc++; if (vf < 0) vf = c; end
      if (sel_chg) begin sc++; if (sf < 0) sf = c; end
      if (c == hold) {next, prev, inc, dec} = 4'b0000;
    end
  endtask

  task automatic test_reset();
    int v, vc, sc, vf, sf;
    bit vch, sch;
    rst = 1'b1; {next, prev, inc, dec} = 4'b0000; sat = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (fields !== '0) begin bad++; $display("FAIL rst_fields got=%0h want=0", fields); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", sel); end
    total++; if (val_chg !== 1'b0) begin bad++; $display("FAIL rst_val_chg got=%b want=0", val_chg); end
    total++; if (sel_chg !== 1'b0) begin bad++; $display("FAIL rst_sel_chg got=%b want=0", sel_chg); end
    inc = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (fields !== '0) begin bad++; $display("FAIL midpress_rst_fields got=%0h want=0", fields); end
    rst = 1'b0;
    v = 0;
    repeat (40) begin @(negedge clk); if (val_chg) v++; end
    total++; if (v !== 0) begin bad++; $display("FAIL held_thru_rst_pulses got=%0d want=0", v); end
    total++; if (fields !== '0) begin bad++; $display("FAIL held_thru_rst_fields got=%0h want=0", fields); end
    inc = 1'b0;
    repeat (DB + 6) @(negedge clk);
    for (int i = 0; i < F; i++) m_f[i] = 0;
    m_sel = 0;
    model_apply(4'b0010, 1'b0, vch, sch);
    press(4'b0010, 1'b0, DB + 8, vc, sc, vf, sf);
    total++; if (vf !== DB + 3) begin bad++; $display("FAIL first_press_latency got=%0d want=%0d", vf, DB + 3); end
    total++; if (vc !== 1) begin bad++; $display("FAIL first_press_pulses got=%0d want=1", vc); end
    total++; if (fields !== model_fields()) begin bad++; $display("FAIL first_press_fields got=%0h want=%0h", fields, model_fields()); end
  endtask

  task automatic test_bounce();
    int v;
    bit vch, sch;
    v = 0;
    sat = 1'b0;
    for (int b = 0; b < 3; b++) begin
      inc = 1'b1; repeat (4) begin @(negedge clk); if (val_chg) v++; end
      inc = 1'b0; repeat (4) begin @(negedge clk); if (val_chg) v++; end
    end
    inc = 1'b1; repeat (DB + 8) begin @(negedge clk); if (val_chg) v++; end
    inc = 1'b0; repeat (DB + 6) begin @(negedge clk); if (val_chg) v++; end
    model_apply(4'b0010, 1'b0, vch, sch);
    total++; if (v !== 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", v); end
    total++; if (fields !== model_fields()) begin bad++; $display("FAIL bounce_fields got=%0h want=%0h", fields, model_fields()); end
  endtask

  task automatic test_saturate();
    logic [4:0] steps[$];
    int vc, sc, vf, sf;
    bit vch, sch;
    for (int i = 0; i <= m_f[m_sel]; i++) steps.push_back({1'b0, 4'b0001});
    steps.push_back({1'b0, 4'b0010});
    steps.push_back({1'b0, 4'b0001});
    steps.push_back({1'b1, 4'b0010});
    steps.push_back({1'b0, 4'b1000});
    steps.push_back({1'b1, 4'b0001});
    steps.push_back({1'b0, 4'b0100});
    foreach (steps[k]) begin
      model_apply(steps[k][3:0], steps[k][4], vch, sch);
      press(steps[k][3:0], steps[k][4], DB + 8, vc, sc, vf, sf);
      total++; if (vc !== int'(vch)) begin bad++; $display("FAIL sat_val_chg step%0d got=%0d want=%0d", k, vc, vch); end
      total++; if (fields !== model_fields()) begin bad++; $display("FAIL sat_fields step%0d got=%0h want=%0h", k, fields, model_fields()); end
    end
  endtask

  task automatic test_select();
    logic [3:0] steps[$];
    int vc, sc, vf, sf;
    bit vch, sch;
    steps = '{4'b0100, 4'b1000, 4'b1100};
    foreach (steps[k]) begin
      model_apply(steps[k], 1'b0, vch, sch);
      press(steps[k], 1'b0, DB + 8, vc, sc, vf, sf);
      total++; if (sel !== 2'(m_sel)) begin bad++; $display("FAIL sel_value step%0d got=%0d want=%0d", k, sel, m_sel); end
      total++; if (sc !== int'(sch)) begin bad++; $display("FAIL sel_chg step%0d got=%0d want=%0d", k, sc, sch); end
    end
  endtask

  task automatic test_combined();
    int vc, sc, vf, sf;
    bit vch, sch;
    model_apply(4'b1010, 1'b0, vch, sch);
    press(4'b1010, 1'b0, DB + 8, vc, sc, vf, sf);
    total++; if (vc !== 1 || sc !== 1) begin bad++; $display("FAIL combo_pulses got=%0d/%0d want=1/1", vc, sc); end
    total++; if (vf !== sf) begin bad++; $display("FAIL combo_same_cycle got=%0d want=%0d", sf, vf); end
    total++; if (fields !== model_fields()) begin bad++; $display("FAIL combo_fields got=%0h want=%0h", fields, model_fields()); end
    total++; if (sel !== 2'(m_sel)) begin bad++; $display("FAIL combo_sel got=%0d want=%0d", sel, m_sel); end
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic s;
    int vc, sc, vf, sf;
    bit vch, sch;
    for (int k = 0; k < 25; k++) begin
      m = 4'($urandom_range(1, 15));
      s = 1'($urandom_range(0, 1));
      model_apply(m, s, vch, sch);
      press(m, s, DB + 8, vc, sc, vf, sf);
      total++; if (fields !== model_fields()) begin bad++; $display("FAIL rand_fields it%0d m=%b got=%0h want=%0h", k, m, fields, model_fields()); end
      total++; if (sel !== 2'(m_sel)) begin bad++; $display("FAIL rand_sel it%0d got=%0d want=%0d", k, sel, m_sel); end
      total++; if (vc !== int'(vch) || sc !== int'(sch)) begin bad++; $display("FAIL rand_pulses it%0d got=%0d/%0d want=%0d/%0d", k, vc, sc, vch, sch); end
    end
  endtask

  task automatic test_hold();
    int vc, sc, vf, sf;
    bit vch, sch;
    for (int n = 0; n < HOLD_STEPS; n++) model_apply(4'b0010, 1'b0, vch, sch);
    press(4'b0010, 1'b0, 105, vc, sc, vf, sf);
    total++; if (vc !== HOLD_STEPS) begin bad++; $display("FAIL hold_steps got=%0d want=%0d", vc, HOLD_STEPS); end
    total++; if (fields !== model_fields()) begin bad++; $display("FAIL hold_fields got=%0h want=%0h", fields, model_fields()); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_saturate();
    test_select();
    test_combined();
    test_random();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
